// File: rtl/writeback_stage.sv
// Writeback stage: retires instructions from the memory stage, aligns load data big-endian and
// drives the register file write port. Optional retire_count output under WB_RETIRE_COUNT_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        nRST,
  input  logic        mw_valid,
  output logic        mw_ready,
  input  logic        mw_regwen,
  input  logic [4:0]  mw_wsel,
  input  logic [31:0] mw_result,
  input  logic        mw_memtoreg,
  input  logic [2:0]  mw_ldtype,
  input  logic        mw_halt,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        fwd_valid,
  output logic [4:0]  fwd_sel,
  output logic [31:0] fwd_dat,
  output logic        misalign_err,
  output logic        halt
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {StIdle, StLoadWait, StWrite, StHalted} state_e;

  localparam logic [2:0] LdLw  = 3'd0;
  localparam logic [2:0] LdLh  = 3'd1;
  localparam logic [2:0] LdLhu = 3'd2;
  localparam logic [2:0] LdLb  = 3'd3;
  localparam logic [2:0] LdLbu = 3'd4;

  state_e      state_q, state_d;
  logic [4:0]  wsel_q, wsel_d;
  logic        regwen_q, regwen_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [1:0]  addr_q, addr_d;
  word_t       wdat_q, wdat_d;
  logic        misalign_q, misalign_d;
  logic        halt_q, halt_d;

  logic        accept;
  logic        in_write;
  logic        ld_misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  word_t       load_data;

  assign in_write = (state_q == StWrite);
  assign mw_ready = (state_q == StIdle) || in_write;
  assign accept   = mw_valid && mw_ready;

  always_comb begin
    ld_misaligned = 1'b0;
    case (mw_ldtype)
      LdLb, LdLbu: ld_misaligned = 1'b0;
      LdLh, LdLhu: ld_misaligned = mw_result[0];
      default:     ld_misaligned = |mw_result[1:0];
    endcase
  end

  // Big-endian lanes: byte 0 and half 0 live in the most significant bits.
  always_comb begin
    ld_byte = dmem_rdata[31:24];
    case (addr_q)
      2'd0:    ld_byte = dmem_rdata[31:24];
      2'd1:    ld_byte = dmem_rdata[23:16];
      2'd2:    ld_byte = dmem_rdata[15:8];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    load_data = dmem_rdata;
    case (ldtype_q)
      LdLh:    load_data = {{16{ld_half[15]}}, ld_half};
      LdLhu:   load_data = {16'h0000, ld_half};
      LdLb:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LdLbu:   load_data = {24'h000000, ld_byte};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wsel_d     = wsel_q;
    regwen_d   = regwen_q;
    ldtype_d   = ldtype_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    misalign_d = misalign_q;
    halt_d     = halt_q;
    unique case (state_q)
      StIdle, StWrite: begin
        state_d = StIdle;
        if (accept) begin
          if (mw_halt) begin
            state_d = StHalted;
            halt_d  = 1'b1;
          end else begin
            wsel_d     = mw_wsel;
            regwen_d   = mw_regwen;
            misalign_d = 1'b0;
            if (!mw_memtoreg) begin
              wdat_d  = mw_result;
              state_d = StWrite;
            end else begin
              ldtype_d = mw_ldtype;
              addr_d   = mw_result[1:0];
              // A misaligned load needs no data; retire it straight away with the write killed.
              if (ld_misaligned) begin
                misalign_d = 1'b1;
                state_d    = StWrite;
              end else begin
                state_d = StLoadWait;
              end
            end
          end
        end
      end
      StLoadWait: begin
        if (dmem_valid) begin
          wdat_d  = load_data;
          state_d = StWrite;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      wsel_q     <= '0;
      regwen_q   <= 1'b0;
      ldtype_q   <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      misalign_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wsel_q     <= wsel_d;
      regwen_q   <= regwen_d;
      ldtype_q   <= ldtype_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      misalign_q <= misalign_d;
      halt_q     <= halt_d;
    end
  end

  assign rf_wen       = in_write && regwen_q && (wsel_q != 5'd0) && !misalign_q;
  assign rf_wsel      = in_write ? wsel_q : 5'd0;
  assign rf_wdat      = in_write ? wdat_q : '0;
  assign fwd_valid    = rf_wen;
  assign fwd_sel      = rf_wsel;
  assign fwd_dat      = rf_wdat;
  assign misalign_err = in_write && misalign_q;
  assign halt         = halt_q;

`ifdef WB_RETIRE_COUNT_EN
  word_t count_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (in_write) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign retire_count = count_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: writes, aligned loads, misalignment,
// halt and reset behaviour.
module tb_writeback_stage;

  logic        clk;
  logic        nRST;
  logic        mw_valid;
  logic        mw_ready;
  logic        mw_regwen;
  logic [4:0]  mw_wsel;
  logic [31:0] mw_result;
  logic        mw_memtoreg;
  logic [2:0]  mw_ldtype;
  logic        mw_halt;
  logic        dmem_valid;
  logic [31:0] dmem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic        fwd_valid;
  logic [4:0]  fwd_sel;
  logic [31:0] fwd_dat;
  logic        misalign_err;
  logic        halt;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  writeback_stage dut (
    .clk          (clk),
    .nRST         (nRST),
    .mw_valid     (mw_valid),
    .mw_ready     (mw_ready),
    .mw_regwen    (mw_regwen),
    .mw_wsel      (mw_wsel),
    .mw_result    (mw_result),
    .mw_memtoreg  (mw_memtoreg),
    .mw_ldtype    (mw_ldtype),
    .mw_halt      (mw_halt),
    .dmem_valid   (dmem_valid),
    .dmem_rdata   (dmem_rdata),
    .rf_wen       (rf_wen),
    .rf_wsel      (rf_wsel),
    .rf_wdat      (rf_wdat),
    .fwd_valid    (fwd_valid),
    .fwd_sel      (fwd_sel),
    .fwd_dat      (fwd_dat),
    .misalign_err (misalign_err),
    .halt         (halt)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mw_valid    = 1'b0;
    mw_regwen   = 1'b0;
    mw_wsel     = 5'd0;
    mw_result   = 32'd0;
    mw_memtoreg = 1'b0;
    mw_ldtype   = 3'd0;
    mw_halt     = 1'b0;
    dmem_valid  = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  task automatic drive_op(input logic regwen, input logic [4:0] wsel, input logic [31:0] result,
                          input logic memtoreg, input logic [2:0] ldtype);
    mw_valid    = 1'b1;
    mw_regwen   = regwen;
    mw_wsel     = wsel;
    mw_result   = result;
    mw_memtoreg = memtoreg;
    mw_ldtype   = ldtype;
    mw_halt     = 1'b0;
  endtask

  // Aligned load: accept, one wait cycle, then data; expect the aligned value one cycle later.
  task automatic do_load(input string tag, input logic [2:0] ldtype, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp);
    drive_op(1'b1, 5'd12, addr, 1'b1, ldtype);
    step();
    clear_inputs();
    check({tag, "_ready_wait"}, {31'd0, mw_ready}, 32'd0);
    dmem_valid = 1'b1;
    dmem_rdata = data;
    step();
    clear_inputs();
    check({tag, "_wen"}, {31'd0, rf_wen}, 32'd1);
    check({tag, "_wdat"}, rf_wdat, exp);
    step();
  endtask

  // Misaligned load: exactly one misalign_err pulse, no write, back to idle.
  task automatic do_misaligned(input string tag, input logic [2:0] ldtype,
                               input logic [31:0] addr);
    int pulses;
    int writes;
    pulses = 0;
    writes = 0;
    drive_op(1'b1, 5'd10, addr, 1'b1, ldtype);
    for (int i = 0; i < 6; i++) begin
      step();
      clear_inputs();
      if (i == 2) begin
        dmem_valid = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
      end
      if (misalign_err) pulses++;
      if (rf_wen) writes++;
    end
    clear_inputs();
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_writes"}, writes, 32'd0);
    check({tag, "_ready"}, {31'd0, mw_ready}, 32'd1);
  endtask

  initial begin
    int wen_seen;
    clear_inputs();
    nRST = 1'b0;
    #22;
    check("rst_ready", {31'd0, mw_ready}, 32'd1);
    check("rst_wen", {31'd0, rf_wen}, 32'd0);
    check("rst_wdat", rf_wdat, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
`ifdef WB_RETIRE_COUNT_EN
    check("rst_count", retire_count, 32'd0);
`endif
    step();
    nRST = 1'b1;
    step();

    // ADD-like write, single cycle.
    drive_op(1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'd0);
    step();
    clear_inputs();
    check("add_wen", {31'd0, rf_wen}, 32'd1);
    check("add_wsel", {27'd0, rf_wsel}, 32'd5);
    check("add_wdat", rf_wdat, 32'h0000_1234);
    check("add_fwd_valid", {31'd0, fwd_valid}, 32'd1);
    check("add_fwd_sel", {27'd0, fwd_sel}, 32'd5);
    check("add_fwd_dat", fwd_dat, 32'h0000_1234);
    step();
    check("add_one_cycle", {31'd0, rf_wen}, 32'd0);
`ifdef WB_RETIRE_COUNT_EN
    check("add_count", retire_count, 32'd1);
`endif

    // Back-to-back writes.
    drive_op(1'b1, 5'd1, 32'h0000_0011, 1'b0, 3'd0);
    step();
    check("b2b_a_wsel", {27'd0, rf_wsel}, 32'd1);
    check("b2b_a_ready", {31'd0, mw_ready}, 32'd1);
    drive_op(1'b1, 5'd2, 32'h0000_0022, 1'b0, 3'd0);
    step();
    clear_inputs();
    check("b2b_b_wen", {31'd0, rf_wen}, 32'd1);
    check("b2b_b_wsel", {27'd0, rf_wsel}, 32'd2);
    check("b2b_b_wdat", rf_wdat, 32'h0000_0022);
    step();

    // Writes to r0 and with regwen low are suppressed.
    drive_op(1'b1, 5'd0, 32'h0000_7777, 1'b0, 3'd0);
    step();
    clear_inputs();
    check("r0_wen", {31'd0, rf_wen}, 32'd0);
    step();
`ifdef WB_RETIRE_COUNT_EN
    check("r0_count", retire_count, 32'd4);
`endif
    drive_op(1'b0, 5'd7, 32'h0000_7777, 1'b0, 3'd0);
    step();
    clear_inputs();
    check("noreg_wen", {31'd0, rf_wen}, 32'd0);
    step();

    // LB at address 3, data three cycles later; dmem_valid at acceptance is ignored.
    drive_op(1'b1, 5'd8, 32'h0000_0003, 1'b1, 3'd3);
    dmem_valid = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      check("lb_ready_wait", {31'd0, mw_ready}, 32'd0);
      check("lb_no_early_wen", {31'd0, rf_wen}, 32'd0);
      step();
    end
    dmem_valid = 1'b1;
    dmem_rdata = 32'h0000_00F0;
    step();
    clear_inputs();
    check("lb_wen", {31'd0, rf_wen}, 32'd1);
    check("lb_wsel", {27'd0, rf_wsel}, 32'd8);
    check("lb_wdat", rf_wdat, 32'hFFFF_FFF0);
    step();
    check("lb_idle_ready", {31'd0, mw_ready}, 32'd1);

    do_load("lhu2", 3'd2, 32'h0000_0002, 32'h0000_ABCD, 32'h0000_ABCD);
    do_load("lh0", 3'd1, 32'h0000_0100, 32'h8001_5555, 32'hFFFF_8001);
    do_load("lbu1", 3'd4, 32'h0000_0001, 32'h00C3_0000, 32'h0000_00C3);
    do_load("lb0", 3'd3, 32'h0000_0000, 32'h7F00_0000, 32'h0000_007F);
    do_load("lw0", 3'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("ld7", 3'd7, 32'h0000_0020, 32'h0BAD_F00D, 32'h0BAD_F00D);

    do_misaligned("lw6", 3'd0, 32'h0000_0006);
    do_misaligned("lh1", 3'd1, 32'h0000_0001);

    // Reset during LOAD_WAIT; late dmem_valid must not write.
    drive_op(1'b1, 5'd11, 32'h0000_0000, 1'b1, 3'd0);
    step();
    clear_inputs();
    check("rstlw_waiting", {31'd0, mw_ready}, 32'd0);
    #2;
    nRST = 1'b0;
    #1;
    check("rstlw_ready", {31'd0, mw_ready}, 32'd1);
    step();
    nRST = 1'b1;
    wen_seen = 0;
    dmem_valid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rf_wen) wen_seen++;
    end
    clear_inputs();
    check("rstlw_no_write", wen_seen, 32'd0);

    // Reset during WRITE drops the write immediately.
    drive_op(1'b1, 5'd13, 32'h0000_ABAB, 1'b0, 3'd0);
    step();
    clear_inputs();
    check("rstwr_pre_wen", {31'd0, rf_wen}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("rstwr_wen", {31'd0, rf_wen}, 32'd0);
    step();
    nRST = 1'b1;
    step();

    // HALT is sticky until reset.
    drive_op(1'b1, 5'd3, 32'h0000_0099, 1'b0, 3'd0);
    mw_halt = 1'b1;
    step();
    clear_inputs();
    check("halt_set", {31'd0, halt}, 32'd1);
    check("halt_no_wen", {31'd0, rf_wen}, 32'd0);
    wen_seen = 0;
    drive_op(1'b1, 5'd4, 32'h0000_0044, 1'b0, 3'd0);
    dmem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("halt_ready", {31'd0, mw_ready}, 32'd0);
      step();
      if (rf_wen) wen_seen++;
    end
    clear_inputs();
    check("halt_ignored", wen_seen, 32'd0);
    check("halt_sticky", {31'd0, halt}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("halt_cleared", {31'd0, halt}, 32'd0);
    check("halt_rst_ready", {31'd0, mw_ready}, 32'd1);
    step();
    nRST = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
